// File: rtl/spu_sm_pkg.sv
// Shared types and constants for the softmax row-max (xmax) control slice.
//   SM_LANES / SM_DW : lanes per score-buffer beat and bits per lane
//   SM_NEG_FLOOR     : neutral pad value for masked lanes (-127)
//   sm_state_e       : row sequencer state encoding
package spu_sm_pkg;

  localparam int unsigned SM_LANES = 8;
  localparam int unsigned SM_DW    = 8;

  localparam logic signed [SM_DW-1:0] SM_NEG_FLOOR = 8'sh81;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sm_state_e;

endpackage

// File: rtl/spu_sm_max_ctrl_if.sv
// Command/result handshake between the SPU softmax sequencer and the row-max
// controller.
//   cmd_valid/cmd_ready : row command handshake (cmd_base, cmd_len payload)
//   res_valid/res_ready : row result handshake (res_max payload, signed)
//   master modport      : sequencer side
//   slave modport       : controller side
interface spu_sm_max_ctrl_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned LEN_W  = 12
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_base;
  logic [LEN_W-1:0]  cmd_len;
  logic              res_valid;
  logic              res_ready;
  logic [7:0]        res_max;

  modport master (
    output cmd_valid, cmd_base, cmd_len, res_ready,
    input  cmd_ready, res_valid, res_max
  );

  modport slave (
    input  cmd_valid, cmd_base, cmd_len, res_ready,
    output cmd_ready, res_valid, res_max
  );

endinterface

// File: rtl/spu_sm_rd_pipe.sv
// RD_LAT-deep shift register tracking {valid, last} for each granted buffer
// read, so the tag reaches its output in the same cycle as the read data.
//   core_clk, rst_n       : clock, async active-low clear
//   push_valid, push_last : tag of a read issued this cycle
//   out_valid, out_last   : tag aligned with the returning rd_data
//   empty                 : no read in flight in any stage
module spu_sm_rd_pipe #(
  parameter int unsigned RD_LAT = 2
) (
  input  logic core_clk,
  input  logic rst_n,
  input  logic push_valid,
  input  logic push_last,
  output logic out_valid,
  output logic out_last,
  output logic empty
);

  logic [RD_LAT-1:0] valid_q, valid_d;
  logic [RD_LAT-1:0] last_q,  last_d;

  // Shift toward the MSB; the oldest stage falls off the top.
  always_comb begin
    valid_d = RD_LAT'({valid_q, push_valid});
    last_d  = RD_LAT'({last_q, push_valid & push_last});
  end

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      last_q  <= '0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q[RD_LAT-1];
  assign out_last  = last_q[RD_LAT-1];
  assign empty     = ~|valid_q;

endmodule

// File: rtl/spu_sm_max_ctrl.sv
// Row sequencer for the 8-lane softmax row-max stage. Per command it clears
// the xmax accumulator, reads ceil(len/8) beats from the score buffer, pads
// the tail lanes of the last beat with -127 and returns the row maximum.
//   core_clk, rst_n     : clock, async active-low reset
//   seq_if (slave)      : cmd_* row command in, res_* row maximum out
//   rd_en/rd_gnt        : beat read request / grant (issue = rd_en & rd_gnt)
//   rd_addr, rd_data    : beat address out, beat data in (RD_LAT later)
//   sm_data             : beat to xmax with masked lanes forced to 8'h81
//   comp_en, comp_rst   : xmax accumulate / clear strobes
//   max_comp            : xmax accumulator value
//   perf_cycles         : command-to-result cycle count, present only when
//                         SPU_SM_MAX_CTRL_PERF_EN is defined
// comp_rst and sm_data are combinational: comp_rst must clear xmax in the
// accept cycle so a zero-length row can report -127 two cycles later, and
// sm_data must qualify rd_data in the cycle it returns.
module spu_sm_max_ctrl
  import spu_sm_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned LEN_W  = 12,
  parameter int unsigned RD_LAT = 2
) (
  input  logic                      core_clk,
  input  logic                      rst_n,
  spu_sm_max_ctrl_if.slave          seq_if,
  output logic                      rd_en,
  input  logic                      rd_gnt,
  output logic [ADDR_W-1:0]         rd_addr,
  input  logic [SM_LANES*SM_DW-1:0] rd_data,
  output logic [SM_LANES*SM_DW-1:0] sm_data,
  output logic                      comp_en,
  output logic                      comp_rst,
  input  logic [SM_DW-1:0]          max_comp
`ifdef SPU_SM_MAX_CTRL_PERF_EN
  ,
  output logic [15:0]               perf_cycles
`endif
);

  localparam int unsigned BEAT_W = LEN_W - 2;

  sm_state_e             state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
  logic [BEAT_W-1:0]     beat_idx_q, beat_idx_d;
  logic [BEAT_W-1:0]     nbeats_q, nbeats_d;
  logic [SM_LANES-1:0]   last_mask_q, last_mask_d;
  logic                  res_valid_q, res_valid_d;
  logic [SM_DW-1:0]      res_max_q, res_max_d;

  logic                  accept_c;
  logic                  issue_c;
  logic                  last_beat_c;
  logic                  res_hs_c;
  logic [LEN_W:0]        len_rnd_c;
  logic [BEAT_W-1:0]     nbeats_c;
  logic [3:0]            lane_cnt_c;
  logic [SM_LANES-1:0]   last_mask_c;
  logic                  pipe_valid;
  logic                  pipe_last;
  logic                  pipe_empty;

  assign accept_c    = (state_q == IDLE) & cmd_ready_q & seq_if.cmd_valid;
  assign issue_c     = rd_en_q & rd_gnt;
  assign last_beat_c = (beat_idx_q == (nbeats_q - BEAT_W'(1)));
  assign res_hs_c    = res_valid_q & seq_if.res_ready;

  // Command decode: beat count and valid-lane mask of the final beat.
  always_comb begin
    len_rnd_c  = {1'b0, seq_if.cmd_len} + (LEN_W+1)'(7);
    nbeats_c   = BEAT_W'(len_rnd_c >> 3);
    lane_cnt_c = (seq_if.cmd_len[2:0] == 3'd0) ? 4'd8 : {1'b0, seq_if.cmd_len[2:0]};
    for (int unsigned i = 0; i < SM_LANES; i++) begin
      last_mask_c[i] = (4'(i) < lane_cnt_c);
    end
  end

  // Row sequencer next-state and registered outputs.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rd_en_d     = rd_en_q;
    rd_addr_d   = rd_addr_q;
    beat_idx_d  = beat_idx_q;
    nbeats_d    = nbeats_q;
    last_mask_d = last_mask_q;
    res_valid_d = res_valid_q;
    res_max_d   = res_max_q;

    unique case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (accept_c) begin
          cmd_ready_d = 1'b0;
          rd_addr_d   = seq_if.cmd_base;
          beat_idx_d  = '0;
          nbeats_d    = nbeats_c;
          last_mask_d = last_mask_c;
          if (seq_if.cmd_len == '0) begin
            state_d = DRAIN;
          end else begin
            state_d = FETCH;
            rd_en_d = 1'b1;
          end
        end
      end
      FETCH: begin
        // Address only moves on a grant; it wraps modulo 2^ADDR_W.
        if (issue_c) begin
          beat_idx_d = beat_idx_q + BEAT_W'(1);
          rd_addr_d  = rd_addr_q + ADDR_W'(1);
          if (last_beat_c) begin
            rd_en_d = 1'b0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // First empty cycle: the final comp_en has been folded into max_comp.
        if (pipe_empty) begin
          res_max_d   = max_comp;
          res_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (res_hs_c) begin
          res_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      beat_idx_q  <= '0;
      nbeats_q    <= '0;
      last_mask_q <= '0;
      res_valid_q <= 1'b0;
      res_max_q   <= SM_NEG_FLOOR;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      beat_idx_q  <= beat_idx_d;
      nbeats_q    <= nbeats_d;
      last_mask_q <= last_mask_d;
      res_valid_q <= res_valid_d;
      res_max_q   <= res_max_d;
    end
  end

  spu_sm_rd_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .core_clk   (core_clk),
    .rst_n      (rst_n),
    .push_valid (issue_c),
    .push_last  (last_beat_c),
    .out_valid  (pipe_valid),
    .out_last   (pipe_last),
    .empty      (pipe_empty)
  );

  // Lanes beyond the row end, and idle cycles, present the neutral value.
  always_comb begin
    sm_data = rd_data;
    for (int unsigned i = 0; i < SM_LANES; i++) begin
      if (!pipe_valid || (pipe_last && !last_mask_q[i])) begin
        sm_data[i*SM_DW +: SM_DW] = SM_NEG_FLOOR;
      end
    end
  end

  assign rd_en            = rd_en_q;
  assign rd_addr          = rd_addr_q;
  assign comp_en          = pipe_valid;
  assign comp_rst         = accept_c;
  assign seq_if.cmd_ready = cmd_ready_q;
  assign seq_if.res_valid = res_valid_q;
  assign seq_if.res_max   = res_max_q;

`ifdef SPU_SM_MAX_CTRL_PERF_EN
  logic [15:0] perf_q, perf_d;
  logic        perf_run_q, perf_run_d;

  // Saturating command-to-result cycle counter; holds after the handshake.
  always_comb begin
    perf_d     = perf_q;
    perf_run_d = perf_run_q;
    if (accept_c) begin
      perf_d     = '0;
      perf_run_d = 1'b1;
    end else if (perf_run_q) begin
      if (perf_q != 16'hFFFF) begin
        perf_d = perf_q + 16'd1;
      end
      if (res_hs_c) begin
        perf_run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q     <= '0;
      perf_run_q <= 1'b0;
    end else begin
      perf_q     <= perf_d;
      perf_run_q <= perf_run_d;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_spu_sm_max_ctrl.sv
// Self-checking bench for spu_sm_max_ctrl: buffer and xmax models around the
// DUT, expected beats/addresses/row maxima queued at command issue and
// compared as the DUT produces them.
module tb_spu_sm_max_ctrl;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned LEN_W  = 12;
  localparam int unsigned RD_LAT = 2;
  localparam logic [7:0]  NEG    = 8'h81;

  logic              core_clk = 1'b0;
  logic              rst_n    = 1'b0;
  logic              rd_en, rd_gnt, comp_en, comp_rst;
  logic [ADDR_W-1:0] rd_addr;
  logic [63:0]       rd_data, sm_data;
  logic [7:0]        max_comp;
`ifdef SPU_SM_MAX_CTRL_PERF_EN
  logic [15:0]       perf_cycles;
`endif

  always #5 core_clk = ~core_clk;

  spu_sm_max_ctrl_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) sif ();

  spu_sm_max_ctrl #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .core_clk (core_clk),
    .rst_n    (rst_n),
    .seq_if   (sif.slave),
    .rd_en    (rd_en),
    .rd_gnt   (rd_gnt),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .sm_data  (sm_data),
    .comp_en  (comp_en),
    .comp_rst (comp_rst),
    .max_comp (max_comp)
`ifdef SPU_SM_MAX_CTRL_PERF_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Score buffer model with fixed read latency; idle cycles return junk.
  logic [63:0] mem [0:1023];
  logic [63:0] dly [RD_LAT];
  always @(posedge core_clk) begin
    dly[0] <= (rd_en && rd_gnt) ? mem[rd_addr] : 64'hA5A5_5A5A_0F0F_F0F0;
    for (int i = 1; i < RD_LAT; i++) dly[i] <= dly[i-1];
  end
  assign rd_data = dly[RD_LAT-1];

  // xmax datapath model.
  function automatic logic signed [7:0] beat_max(input logic signed [7:0] a, input logic [63:0] d);
    logic signed [7:0] m;
    m = a;
    for (int i = 0; i < 8; i++) if ($signed(d[8*i +: 8]) > m) m = $signed(d[8*i +: 8]);
    return m;
  endfunction

  logic signed [7:0] acc;
  always @(posedge core_clk or negedge rst_n) begin
    if (!rst_n)       acc <= $signed(NEG);
    else if (comp_rst) acc <= $signed(NEG);
    else if (comp_en)  acc <= beat_max(acc, sm_data);
  end
  assign max_comp = acc;

  // Grant pattern: 0 = always, 1 = toggle, 2 = random.
  int gnt_mode = 0;
  initial begin
    rd_gnt = 1'b1;
    forever begin
      @(posedge core_clk);
      #1;
      case (gnt_mode)
        1:       rd_gnt = ~rd_gnt;
        2:       rd_gnt = 1'($urandom_range(0, 1));
        default: rd_gnt = 1'b1;
      endcase
    end
  end

  // Scoreboard.
  logic [63:0]       exp_beat_q [$];
  logic [ADDR_W-1:0] exp_addr_q [$];
  logic [7:0]        exp_max_q  [$];

  task automatic push_exp(input int base, input int len);
    int nb, nv;
    logic [ADDR_W-1:0] a;
    logic [63:0] d;
    logic signed [7:0] m, v;
    nb = (len + 7) / 8;
    nv = (len % 8 == 0) ? 8 : len % 8;
    for (int b = 0; b < nb; b++) begin
      a = ADDR_W'(base + b);
      exp_addr_q.push_back(a);
      d = mem[a];
      if (b == nb - 1) for (int l = nv; l < 8; l++) d[8*l +: 8] = NEG;
      exp_beat_q.push_back(d);
    end
    m = $signed(NEG);
    for (int e = 0; e < len; e++) begin
      d = mem[ADDR_W'(base + e / 8)];
      v = $signed(d[8*(e % 8) +: 8]);
      if (v > m) m = v;
    end
    exp_max_q.push_back(m);
  endtask

  // Monitor, sampling mid-cycle.
  int cyc = 0;
  always @(posedge core_clk) cyc <= cyc + 1;

  int res_cnt = 0, comp_en_cnt = 0, rd_cnt = 0, comp_rst_cnt = 0;
  int acc_cyc = 0, last_gnt_cyc = 0;
  logic row_zero = 1'b0, have_prev = 1'b0, prev_en = 1'b0, prev_gnt = 1'b0, prev_rv = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;

  always @(negedge core_clk) begin
    if (rst_n) begin
      if (comp_en) begin
        comp_en_cnt++;
        if (exp_beat_q.size() == 0) chk("comp_en_spur", 64'(1), 64'(0));
        else chk("sm_data", sm_data, exp_beat_q.pop_front());
      end else begin
        chk("sm_idle", sm_data, {8{NEG}});
      end
      if (comp_en && comp_rst) chk("en_rst_overlap", 64'(1), 64'(0));
      if (comp_rst) comp_rst_cnt++;
      if (comp_rst || (sif.cmd_valid && sif.cmd_ready))
        chk("comp_rst", 64'(comp_rst), 64'(sif.cmd_valid && sif.cmd_ready));
      if (sif.cmd_valid && sif.cmd_ready) begin
        row_zero = (sif.cmd_len == '0);
        acc_cyc  = cyc;
      end
      if (rd_en && rd_gnt) begin
        rd_cnt++;
        last_gnt_cyc = cyc;
        if (exp_addr_q.size() == 0) chk("rd_spur", 64'(1), 64'(0));
        else chk("rd_addr", 64'(rd_addr), 64'(exp_addr_q.pop_front()));
      end
      if (have_prev && prev_en && !prev_gnt) begin
        chk("en_hold", 64'(rd_en), 64'(1));
        chk("addr_hold", 64'(rd_addr), 64'(prev_addr));
      end
      if (sif.res_valid && !prev_rv)
        chk("latency", 64'(cyc), row_zero ? 64'(acc_cyc + 2) : 64'(last_gnt_cyc + int'(RD_LAT) + 2));
      if (sif.res_valid && sif.res_ready) begin
        if (exp_max_q.size() == 0) chk("res_spur", 64'(1), 64'(0));
        else chk("res_max", 64'(sif.res_max), 64'(exp_max_q.pop_front()));
        chk("beats_left", 64'(exp_beat_q.size()), 64'(0));
        chk("addrs_left", 64'(exp_addr_q.size()), 64'(0));
        res_cnt++;
      end
      prev_en   = rd_en;
      prev_gnt  = rd_gnt;
      prev_addr = rd_addr;
      prev_rv   = sif.res_valid;
      have_prev = 1'b1;
    end else begin
      have_prev = 1'b0;
      prev_rv   = 1'b0;
    end
  end

  task automatic issue_cmd(input int base, input int len);
    logic ok;
    push_exp(base, len);
    @(posedge core_clk); #1;
    sif.cmd_valid = 1'b1;
    sif.cmd_base  = ADDR_W'(base);
    sif.cmd_len   = LEN_W'(len);
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge core_clk);
      if (sif.cmd_ready) ok = 1'b1;
    end
    if (!ok) chk("accept_timeout", 64'(0), 64'(1));
    @(posedge core_clk); #1;
    sif.cmd_valid = 1'b0;
  endtask

  task automatic wait_res(input int n0);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 600 && !ok; k++) begin
      @(posedge core_clk);
      if (res_cnt > n0) ok = 1'b1;
    end
    if (!ok) chk("done_timeout", 64'(0), 64'(1));
    #1;
  endtask

  task automatic run_cmd(input int base, input int len);
    int n0;
    n0 = res_cnt;
    issue_cmd(base, len);
    wait_res(n0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, en0, rd0, rst0;
    logic ok;
    logic [7:0] held;

    for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom};
    sif.cmd_valid = 1'b0;
    sif.cmd_base  = '0;
    sif.cmd_len   = '0;
    sif.res_ready = 1'b1;

    // Reset values.
    repeat (3) @(posedge core_clk);
    #1;
    chk("rst_cmd_ready", 64'(sif.cmd_ready), 64'(0));
    chk("rst_rd_en",     64'(rd_en),         64'(0));
    chk("rst_comp_en",   64'(comp_en),       64'(0));
    chk("rst_comp_rst",  64'(comp_rst),      64'(0));
    chk("rst_res_valid", 64'(sif.res_valid), 64'(0));
    chk("rst_res_max",   64'(sif.res_max),   64'(NEG));
    rst_n = 1'b1;
    repeat (2) @(negedge core_clk);
    chk("idle_ready", 64'(sif.cmd_ready), 64'(1));

    // Single full beat.
    mem[10'h010] = {8'd1, 8'd99, 8'h80, 8'd0, 8'd7, 8'd100, 8'hFD, 8'd5};
    en0 = comp_en_cnt; rd0 = rd_cnt;
    run_cmd(10'h010, 8);
    chk("t1_res_max", 64'(sif.res_max), 64'(8'd100));
    chk("t1_comp_en", 64'(comp_en_cnt - en0), 64'(1));
    chk("t1_reads",   64'(rd_cnt - rd0), 64'(1));

    // Partial last beat: lanes 5..7 of beat 1 must not win.
    mem[10'h040] = {8'd7, 8'd0, 8'h9C, 8'd49, 8'd3, 8'd20, 8'hFB, 8'd10};
    mem[10'h041] = {8'd120, 8'd120, 8'd120, 8'd8, 8'hFD, 8'd47, 8'd2, 8'd1};
    run_cmd(10'h040, 13);
    chk("t2_res_max", 64'(sif.res_max), 64'(8'd49));

    // Address wrap with grant gaps.
    gnt_mode = 1;
    en0 = comp_en_cnt; rd0 = rd_cnt;
    run_cmd(10'h3FF, 24);
    chk("t3_comp_en", 64'(comp_en_cnt - en0), 64'(3));
    chk("t3_reads",   64'(rd_cnt - rd0), 64'(3));
    gnt_mode = 0;

    // Zero-length row.
    en0 = comp_en_cnt; rd0 = rd_cnt; rst0 = comp_rst_cnt;
    run_cmd(0, 0);
    chk("t4_res_max",  64'(sif.res_max), 64'(NEG));
    chk("t4_comp_en",  64'(comp_en_cnt - en0), 64'(0));
    chk("t4_reads",    64'(rd_cnt - rd0), 64'(0));
    chk("t4_comp_rst", 64'(comp_rst_cnt - rst0), 64'(1));

    // Result back-pressure with a second command waiting.
    sif.res_ready = 1'b0;
    n0 = res_cnt;
    push_exp(10'h020, 8);
    @(posedge core_clk); #1;
    sif.cmd_valid = 1'b1;
    sif.cmd_base  = 10'h020;
    sif.cmd_len   = LEN_W'(8);
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge core_clk);
      if (sif.cmd_ready) ok = 1'b1;
    end
    if (!ok) chk("t5_accept_timeout", 64'(0), 64'(1));
    @(posedge core_clk); #1;
    sif.cmd_base = 10'h030;
    sif.cmd_len  = LEN_W'(16);
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge core_clk);
      if (sif.res_valid) ok = 1'b1;
    end
    if (!ok) chk("t5_res_timeout", 64'(0), 64'(1));
    held = sif.res_max;
    for (int k = 0; k < 5; k++) begin
      chk("t5_rv_hold",   64'(sif.res_valid), 64'(1));
      chk("t5_rm_hold",   64'(sif.res_max),   64'(held));
      chk("t5_cmd_ready", 64'(sif.cmd_ready), 64'(0));
      @(negedge core_clk);
    end
    @(posedge core_clk); #1;
    sif.res_ready = 1'b1;
    @(negedge core_clk);
    @(posedge core_clk); #1;
    push_exp(10'h030, 16);
    @(negedge core_clk);
    chk("t5_ready_after_hs", 64'(sif.cmd_ready), 64'(1));
    chk("t5_comp_rst",       64'(comp_rst),      64'(1));
    @(posedge core_clk); #1;
    sif.cmd_valid = 1'b0;
    wait_res(n0 + 1);

    // Reset in the middle of a long row.
    issue_cmd(10'h100, 64);
    repeat (3) @(posedge core_clk);
    #1;
    rst_n = 1'b0;
    exp_beat_q.delete();
    exp_addr_q.delete();
    exp_max_q.delete();
    #1;
    chk("t6_rd_en",     64'(rd_en),         64'(0));
    chk("t6_comp_en",   64'(comp_en),       64'(0));
    chk("t6_res_valid", 64'(sif.res_valid), 64'(0));
    chk("t6_cmd_ready", 64'(sif.cmd_ready), 64'(0));
    chk("t6_res_max",   64'(sif.res_max),   64'(NEG));
    en0 = comp_en_cnt;
    repeat (2) @(posedge core_clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge core_clk);
    #1;
    chk("t6_no_inflight", 64'(comp_en_cnt - en0), 64'(0));
    run_cmd(10'h200, 20);

    // Random rows with random grant gaps.
    gnt_mode = 2;
    for (int r = 0; r < 6; r++) run_cmd(int'($urandom_range(0, 1023)), int'($urandom_range(1, 40)));
    gnt_mode = 0;

    repeat (3) @(posedge core_clk);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/spu_sm_max_ctrl.md
Name: spu_sm_max_ctrl

Overview:
- Sequences the 8-lane softmax row-max stage (xmax) for one row per command.
- Per row: clears the max accumulator, issues beat reads to the score buffer, and pads the partial final beat with the neutral value -127.
- Drives comp_en in step with the returning data, then returns the row maximum over a valid/ready handshake.
- Sits between the SPU softmax sequencer (command/result side) and the score buffer read port plus the xmax datapath.

Parameters:
- ADDR_W, 10, score buffer beat-address width (one beat = 8 x int8).
- LEN_W, 12, row length field width, in elements.
- RD_LAT, 2, fixed buffer read latency in cycles (granted rd_en to rd_data); legal range 1..4.

Ports:
- core_clk  in  1  clock
- rst_n  in  1  async active-low reset
- cmd_valid  in  1  row command valid
- cmd_ready  out  1  high only in IDLE
- cmd_base  in  ADDR_W  first beat address of the row
- cmd_len  in  LEN_W  row length in elements
- rd_en  out  1  beat read request
- rd_gnt  in  1  buffer grant; a read issues when rd_en & rd_gnt
- rd_addr  out  ADDR_W  beat address
- rd_data  in  64  returned beat; lane i = bits [8i+7:8i], signed
- sm_data  out  64  beat to xmax, with masked lanes forced to 8'h81
- comp_en  out  1  xmax accumulate strobe
- comp_rst  out  1  xmax clear strobe
- max_comp  in  8  xmax accumulator value, signed
- res_valid  out  1  row max available
- res_ready  in  1  consumer accept
- res_max  out  8  signed row maximum

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is core_clk. All outputs reset to 0, except res_max, which resets to 8'h81. State resets to IDLE.
- Beat count: nbeats = ceil(cmd_len/8). Valid lanes in the last beat: cmd_len%8, or 8 if the remainder is 0. Lanes >= that count are forced to 8'h81 (-127). All other beats use all 8 lanes.
- IDLE: cmd_ready=1. On cmd_valid:
  - latch base, nbeats and last-beat mask;
  - assert comp_rst for exactly that cycle;
  - go to FETCH, or to DRAIN if cmd_len==0.
- FETCH:
  - rd_en=1 and rd_addr = base + beat_idx, modulo 2^ADDR_W (wrap is legal).
  - beat_idx advances only on rd_gnt. Without a grant, rd_en and rd_addr hold stable.
  - After the last granted beat, go to DRAIN; rd_en drops the following cycle.
- Read pipe: each granted read pushes {valid, last} into an RD_LAT-deep shift register. At its output:
  - comp_en = valid;
  - sm_data = rd_data, with the mask applied when last=1;
  - when valid=0, sm_data = all lanes 8'h81.
- DRAIN: wait until the pipe is empty. In the first cycle it is empty, load res_max <= max_comp and go to DONE.
- DONE: res_valid=1 and res_max holds. On res_ready, go to IDLE; res_valid drops the next cycle.
- Latency: res_valid rises RD_LAT+2 cycles after the last granted read cycle. For len==0, res_valid rises 2 cycles after accept with res_max=-127.
- comp_en and comp_rst are never asserted in the same cycle. comp_rst always precedes the first comp_en by at least 1 cycle.
- cmd_valid outside IDLE is ignored; cmd_ready=0 there.
- Reset mid-row: the state returns to IDLE and the pipe flushes. Any rd_data still in flight is ignored (no comp_en).
- Gaps in rd_gnt produce gaps in comp_en only; the result is unaffected.

Optional Feature:
- Macro SPU_SM_MAX_CTRL_PERF_EN.
- When defined, adds output perf_cycles (16 bits):
  - cleared on command accept;
  - increments every cycle until the res handshake, then holds;
  - saturates at 16'hFFFF;
  - resets to 0.
- When not defined, the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- Package spu_sm_pkg holds: SM_LANES=8, SM_DW=8, SM_NEG_FLOOR=8'sh81, and the state encoding (IDLE, FETCH, DRAIN, DONE).
- One sub-module, spu_sm_rd_pipe: a parameterised RD_LAT-deep shift register of {valid, last}, with async clear.

Test Plan:
- len=8, base=0x010, gnt=1, data lanes {5,-3,100,7,0,-128,99,1} (xmax model attached) -> one rd_en at addr 0x010; comp_en exactly 1 cycle; res_max=100; res_valid at RD_LAT+2 after the read.
- len=13, two beats; beat 1 lanes 5..7 = 120, other values < 50 -> lanes 5..7 are masked to -127; res_max equals the true max of the first 13 elements, not 120.
- len=24, base=0x3FF, rd_gnt toggling 1,0,1,0,... -> addresses 0x3FF, 0x000, 0x001; rd_addr stable during no-grant cycles; 3 comp_en pulses.
- len=0 -> no rd_en or comp_en; comp_rst pulses once; res_max=-127; res_valid 2 cycles after accept.
- res_ready held 0 for 5 cycles; cmd_valid held 1 -> res_valid/res_max stable; cmd_ready=0; the second command is accepted the cycle after the handshake, with comp_rst.
- rst_n asserted mid-FETCH of len=64 -> outputs reset immediately; no comp_en from in-flight data; the next command completes correctly.
